// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset PC and instruction field positions.
// Pure declarations, no logic and no flow control.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HELD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int JIDX_HI   = 25;
  localparam int JIDX_LO   = 0;

  function automatic logic [31:0] jump_target(input logic [3:0] pc4_hi, input logic [25:0] idx);
    return {pc4_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Redirect detect and target mux: branch beats JR beats J; only a valid IF/ID can redirect.
// Purely combinational, zero latency, no backpressure.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic        if_id_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [1:0]  jump,
  input  logic        j_jump,
  input  logic [31:0] jr_target,
  input  logic [3:0]  pc4_hi,
  input  logic [25:0] instr_index,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = if_id_valid && (branch_taken || (jump == 2'b01) || j_jump);
    if (branch_taken)
      target = branch_target;
    else if (jump == 2'b01)
      target = jr_target;
    else
      target = jump_target(pc4_hi, instr_index);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request, one-entry hold buffer and IF/ID register.
// One instruction per cycle with zero-wait memory; stall holds IF/ID, imem_ready low holds the request.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  Jump,
  input  logic        J_Jump,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_nxt, if_id_instr_nxt, if_id_pc4_nxt;
  logic         if_id_valid_nxt;
  logic [31:0]  hold_instr, hold_instr_nxt, hold_pc4, hold_pc4_nxt;
  logic [31:0]  pend_target, pend_target_nxt;
  logic [31:0]  pc_plus4, redirect_target;
  logic         redirect, req;

  next_pc_sel u_next_pc_sel (
    .if_id_valid  (if_id_valid),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (Jump),
    .j_jump       (J_Jump),
    .jr_target    (jr_target),
    .pc4_hi       (if_id_pc4[31:28]),
    .instr_index  (if_id_instr[JIDX_HI:JIDX_LO]),
    .redirect     (redirect),
    .target       (redirect_target)
  );

  assign pc_plus4  = pc + 32'd4;
  assign imem_req  = req && !reset;
  assign imem_addr = pc;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_id_instr_nxt = if_id_instr;
    if_id_pc4_nxt   = if_id_pc4;
    if_id_valid_nxt = if_id_valid;
    hold_instr_nxt  = hold_instr;
    hold_pc4_nxt    = hold_pc4;
    pend_target_nxt = pend_target;
    req             = 1'b0;
    case (state)
      FETCH, WAIT: begin
        // Once issued, a request stays up until accepted so the address never moves under it.
        req = (state == WAIT) || !(stall && if_id_valid);
        if (redirect) begin
          if_id_valid_nxt = 1'b0;
          if (req && !imem_ready) begin
            pend_target_nxt = redirect_target;
            state_nxt       = DROP;
          end else begin
            pc_nxt    = redirect_target;
            state_nxt = FETCH;
          end
        end else if (req && imem_ready) begin
          pc_nxt = pc_plus4;
          if (stall) begin
            hold_instr_nxt = imem_rdata;
            hold_pc4_nxt   = pc_plus4;
            state_nxt      = HELD;
          end else begin
            if_id_instr_nxt = imem_rdata;
            if_id_pc4_nxt   = pc_plus4;
            if_id_valid_nxt = 1'b1;
            state_nxt       = FETCH;
          end
        end else if (req) begin
          state_nxt = WAIT;
        end
      end
      HELD: begin
        if (redirect) begin
          pc_nxt          = redirect_target;
          if_id_valid_nxt = 1'b0;
          state_nxt       = FETCH;
        end else if (!stall) begin
          if_id_instr_nxt = hold_instr;
          if_id_pc4_nxt   = hold_pc4;
          if_id_valid_nxt = 1'b1;
          state_nxt       = FETCH;
        end
      end
      DROP: begin
        // Stale response for the pre-redirect address is swallowed here.
        req = 1'b1;
        if (imem_ready) begin
          pc_nxt    = pend_target;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      hold_instr  <= 32'h0;
      hold_pc4    <= 32'h0;
      pend_target <= 32'h0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_instr <= if_id_instr_nxt;
      if_id_pc4   <= if_id_pc4_nxt;
      if_id_valid <= if_id_valid_nxt;
      hold_instr  <= hold_instr_nxt;
      hold_pc4    <= hold_pc4_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  assign opcode = if_id_instr[OPCODE_HI:OPCODE_LO];
  assign rs     = if_id_instr[RS_HI:RS_LO];
  assign rt     = if_id_instr[RT_HI:RT_LO];
  assign rd     = if_id_instr[RD_HI:RD_LO];
  assign imm    = if_id_instr[IMM_HI:IMM_LO];
  assign funct  = if_id_instr[FUNCT_HI:FUNCT_LO];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port stall, input, 1 bit: hold the IF/ID register, e.g. for a load-use hazard.
REQ-005 SHALL have ports Jump (input, 2 bits), J_Jump (input, 1 bit), jr_target (input, 32 bits): decode-stage jump controls and the JR register value.
REQ-006 SHALL have ports branch_taken (input, 1 bit) and branch_target (input, 32 bits): resolved branch redirect.
REQ-007 SHALL have ports imem_req (output, 1 bit), imem_addr (output, 32 bits), imem_ready (input, 1 bit), imem_rdata (input, 32 bits): instruction memory request/ready handshake.
REQ-008 SHALL have ports pc (output, 32 bits), if_id_instr (output, 32 bits), if_id_pc4 (output, 32 bits), if_id_valid (output, 1 bit).
REQ-009 SHALL have ports opcode (output, 6 bits), funct (output, 6 bits), rs, rt, rd (outputs, 5 bits each), imm (output, 16 bits): fields sliced from if_id_instr.

Function
REQ-010 SHALL keep at most one memory request outstanding; imem_addr SHALL equal pc and stay stable while imem_req=1 and imem_ready=0.
REQ-011 SHALL use the FSM states FETCH, WAIT, HELD and DROP.
REQ-012 FETCH: SHALL assert imem_req unless stall=1 and if_id_valid=1; when imem_req=1 and imem_ready=0, SHALL go to WAIT.
REQ-013 On a handshake (imem_req=1 and imem_ready=1) with no stall, SHALL load if_id_instr=imem_rdata, if_id_pc4=pc+4 and if_id_valid=1, set pc=pc+4, and stay in FETCH (zero-wait throughput of 1 instruction per cycle).
REQ-014 On a handshake while stall=1, SHALL capture the data in a one-entry hold buffer, set pc=pc+4, go to HELD and leave IF/ID unchanged.
REQ-015 HELD: SHALL keep imem_req=0; on the first cycle with stall=0, SHALL move the buffer into IF/ID and return to FETCH.
REQ-016 Redirect SHALL be evaluated only when if_id_valid=1, with priority branch_taken > (Jump==2'b01, target jr_target) > (J_Jump=1, target {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}).
REQ-017 On a redirect, SHALL set pc=target, clear if_id_valid and empty the hold buffer; a redirect SHALL override stall in the same cycle.
REQ-018 A redirect during WAIT SHALL record the target and go to DROP; DROP SHALL keep the old address until imem_ready, discard that data, load pc=recorded target and go to FETCH.
REQ-019 A redirect in the same cycle as a handshake SHALL discard the returned data.
REQ-020 When stall=1, no redirect and no handshake, SHALL leave every IF/ID output unchanged.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000).
REQ-022 The field outputs SHALL be purely combinational slices of if_id_instr (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0], funct [5:0]).

Reset
REQ-023 While reset=1, SHALL force pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, imem_req=0, state=FETCH, and SHALL empty the hold buffer and pending target, all asynchronously.
REQ-024 Reset asserted mid-WAIT SHALL abandon the request; the first request after reset release SHALL be to RESET_PC.

Structure
REQ-025 FSM state encodings, RESET_PC default and the field bit positions SHALL live in shared package cpu_pkg.
REQ-026 The jump-target and redirect-priority mux SHALL be sub-module next_pc_sel; it SHALL be combinational, while the FSM, PC and IF/ID register stay in fetch_unit.

Verification
REQ-027 Reset then imem_ready=1 constantly -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; if_id_valid=1 from cycle 2.
REQ-028 imem_ready low for 3 cycles at addr 0x8 -> imem_addr held at 0x8 and IF/ID unchanged; advances to 0xC on the cycle after ready.
REQ-029 stall=1 while the handshake at 0x10 completes -> HELD, imem_req=0; on stall release IF/ID = instruction at 0x10 with if_id_pc4=0x14.
REQ-030 IF/ID holds J 0x0000040 at pc4=0x1000_0004 -> next imem_addr=0x1000_0100 and if_id_valid=0 for one cycle.
REQ-031 branch_taken=1 to 0x200 while in WAIT at 0x20 -> DROP; data for 0x20 is discarded and the next request is to 0x200.
REQ-032 branch_taken=1 together with Jump=2'b01 and stall=1 -> pc=branch_target and IF/ID flushed.
